// File: rtl/i2c_enum_type.sv
// Shared I2C target types: FSM states, bus-condition codes and default widths.
package i2c_enum_type;

    localparam int unsigned DEF_ADDR_WIDTH = 7;
    localparam int unsigned DEF_DATA_WIDTH = 8;

    typedef enum logic [3:0] {
        ST_IDLE     = 4'd0,
        ST_ADDR     = 4'd1,
        ST_ADDR_ACK = 4'd2,
        ST_WR_DATA  = 4'd3,
        ST_WR_ACK   = 4'd4,
        ST_RD_LOAD  = 4'd5,
        ST_RD_DATA  = 4'd6,
        ST_RD_ACK   = 4'd7,
        ST_IGNORE   = 4'd8
    } state_e;

    typedef enum logic [1:0] {
        DET_NONE  = 2'd0,
        DET_START = 2'd1,
        DET_STOP  = 2'd2
    } det_e;

    // SCL must already have been high the cycle before, so an SDA edge that
    // coincides with SCL rising (e.g. stretch release) is never a bus condition.
    function automatic det_e detect_cond(input logic scl_lvl, input logic scl_rise,
                                         input logic sda_rise, input logic sda_fall);
        det_e det;
        det = DET_NONE;
        if (scl_lvl && !scl_rise) begin
            if (sda_fall) begin
                det = DET_START;
            end else if (sda_rise) begin
                det = DET_STOP;
            end
        end
        return det;
    endfunction

endpackage

// File: rtl/i2c_sync_edge.sv
// Two-flop synchronizer for one asynchronous bus line, with rise/fall detect.
module i2c_sync_edge (
    input  logic clk_i,
    input  logic rst_i,
    input  logic async_i,
    output logic level_o,
    output logic rise_c_o,
    output logic fall_c_o
);

    logic meta_q;
    logic sync_q;
    logic prev_q;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            meta_q <= 1'b1;
            sync_q <= 1'b1;
            prev_q <= 1'b1;
        end else begin
            meta_q <= async_i;
            sync_q <= meta_q;
            prev_q <= sync_q;
        end
    end

    assign level_o  = sync_q;
    assign rise_c_o = sync_q & ~prev_q;
    assign fall_c_o = ~sync_q & prev_q;

endmodule

// File: rtl/i2c_target_rsp.sv
// I2C target: address match, write receive, read transmit with clock stretching.
module i2c_target_rsp
    import i2c_enum_type::*;
#(
    parameter int unsigned                 I2C_ADDR_WIDTH = DEF_ADDR_WIDTH,
    parameter int unsigned                 I2C_DATA_WIDTH = DEF_DATA_WIDTH,
    parameter logic [I2C_ADDR_WIDTH-1:0]   TARGET_ADDR    = I2C_ADDR_WIDTH'(7'h22)
) (
    input  logic                      clk_i,
    input  logic                      rst_i,
    input  logic                      scl_i,
    input  logic                      sda_i,
    output logic                      scl_o,
    output logic                      sda_o,
    output logic [I2C_DATA_WIDTH-1:0] rx_data_o,
    output logic                      rx_valid_o,
    output logic                      tx_req_o,
    input  logic [I2C_DATA_WIDTH-1:0] tx_data_i,
    input  logic                      tx_valid_i,
    output logic                      start_o,
    output logic                      stop_o,
    output logic                      rw_o,
    output logic                      busy_o
);

    localparam int unsigned AW    = I2C_ADDR_WIDTH;
    localparam int unsigned DW    = I2C_DATA_WIDTH;
    localparam int unsigned MAXW  = (AW > DW) ? AW : DW;
    localparam int unsigned CNT_W = $clog2(MAXW + 1);

    logic scl_lvl, scl_rise, scl_fall;
    logic sda_lvl, sda_rise, sda_fall;
    det_e det;

    i2c_sync_edge u_scl_sync (
        .clk_i    (clk_i),
        .rst_i    (rst_i),
        .async_i  (scl_i),
        .level_o  (scl_lvl),
        .rise_c_o (scl_rise),
        .fall_c_o (scl_fall)
    );

    i2c_sync_edge u_sda_sync (
        .clk_i    (clk_i),
        .rst_i    (rst_i),
        .async_i  (sda_i),
        .level_o  (sda_lvl),
        .rise_c_o (sda_rise),
        .fall_c_o (sda_fall)
    );

    assign det = detect_cond(scl_lvl, scl_rise, sda_rise, sda_fall);

    state_e           state_q;
    logic [CNT_W-1:0] cnt_q;
    logic [AW-1:0]    addr_q;
    logic [DW-1:0]    shreg_q;
    logic [DW-1:0]    rx_data_q;
    logic             flag_q;
    logic             scl_q, sda_q;
    logic             rx_valid_q, tx_req_q, start_q, stop_q, rw_q, busy_q;

    // flag_q: in the ACK states it marks "ACK currently driven"; in RD_ACK it
    // records that the controller ACKed, so the reload waits for SCL low.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q    <= ST_IDLE;
            cnt_q      <= '0;
            addr_q     <= '0;
            shreg_q    <= '0;
            rx_data_q  <= '0;
            flag_q     <= 1'b0;
            scl_q      <= 1'b1;
            sda_q      <= 1'b1;
            rx_valid_q <= 1'b0;
            tx_req_q   <= 1'b0;
            start_q    <= 1'b0;
            stop_q     <= 1'b0;
            rw_q       <= 1'b0;
            busy_q     <= 1'b0;
        end else begin
            rx_valid_q <= 1'b0;
            tx_req_q   <= 1'b0;
            start_q    <= 1'b0;
            stop_q     <= 1'b0;
            if (det == DET_START) begin
                state_q <= ST_ADDR;
                cnt_q   <= '0;
                flag_q  <= 1'b0;
                start_q <= 1'b1;
                scl_q   <= 1'b1;
                sda_q   <= 1'b1;
            end else if (det == DET_STOP) begin
                state_q <= ST_IDLE;
                flag_q  <= 1'b0;
                stop_q  <= 1'b1;
                scl_q   <= 1'b1;
                sda_q   <= 1'b1;
                busy_q  <= 1'b0;
            end else begin
                unique case (state_q)
                    ST_IDLE: begin
                    end
                    ST_ADDR: begin
                        if (scl_rise) begin
                            if (cnt_q == CNT_W'(AW)) begin
                                if (addr_q == TARGET_ADDR) begin
                                    rw_q    <= sda_lvl;
                                    busy_q  <= 1'b1;
                                    flag_q  <= 1'b0;
                                    state_q <= ST_ADDR_ACK;
                                end else begin
                                    busy_q  <= 1'b0;
                                    state_q <= ST_IGNORE;
                                end
                            end else begin
                                addr_q <= {addr_q[AW-2:0], sda_lvl};
                                cnt_q  <= cnt_q + CNT_W'(1);
                            end
                        end
                    end
                    ST_ADDR_ACK, ST_WR_ACK: begin
                        if (scl_fall) begin
                            if (!flag_q) begin
                                sda_q  <= 1'b0;
                                flag_q <= 1'b1;
                            end else begin
                                sda_q  <= 1'b1;
                                flag_q <= 1'b0;
                                cnt_q  <= '0;
                                if (state_q == ST_WR_ACK || !rw_q) begin
                                    state_q <= ST_WR_DATA;
                                end else begin
                                    state_q  <= ST_RD_LOAD;
                                    tx_req_q <= 1'b1;
                                end
                            end
                        end
                    end
                    ST_WR_DATA: begin
                        if (scl_rise) begin
                            shreg_q <= {shreg_q[DW-2:0], sda_lvl};
                            if (cnt_q == CNT_W'(DW - 1)) begin
                                rx_data_q  <= {shreg_q[DW-2:0], sda_lvl};
                                rx_valid_q <= 1'b1;
                                flag_q     <= 1'b0;
                                cnt_q      <= '0;
                                state_q    <= ST_WR_ACK;
                            end else begin
                                cnt_q <= cnt_q + CNT_W'(1);
                            end
                        end
                    end
                    ST_RD_LOAD: begin
                        if (tx_valid_i) begin
                            shreg_q <= {tx_data_i[DW-2:0], 1'b0};
                            sda_q   <= tx_data_i[DW-1];
                            scl_q   <= 1'b1;
                            cnt_q   <= CNT_W'(1);
                            state_q <= ST_RD_DATA;
                        end else begin
                            scl_q <= 1'b0;
                        end
                    end
                    ST_RD_DATA: begin
                        if (scl_fall) begin
                            if (cnt_q == CNT_W'(DW)) begin
                                sda_q   <= 1'b1;
                                flag_q  <= 1'b0;
                                state_q <= ST_RD_ACK;
                            end else begin
                                sda_q   <= shreg_q[DW-1];
                                shreg_q <= {shreg_q[DW-2:0], 1'b0};
                                cnt_q   <= cnt_q + CNT_W'(1);
                            end
                        end
                    end
                    ST_RD_ACK: begin
                        if (scl_rise) begin
                            if (!sda_lvl) begin
                                flag_q <= 1'b1;
                            end else begin
                                state_q <= ST_IGNORE;
                            end
                        end else if (scl_fall && flag_q) begin
                            flag_q   <= 1'b0;
                            tx_req_q <= 1'b1;
                            state_q  <= ST_RD_LOAD;
                        end
                    end
                    ST_IGNORE: begin
                        scl_q <= 1'b1;
                        sda_q <= 1'b1;
                    end
                    default: begin
                        state_q <= ST_IDLE;
                    end
                endcase
            end
        end
    end

    assign scl_o      = scl_q;
    assign sda_o      = sda_q;
    assign rx_data_o  = rx_data_q;
    assign rx_valid_o = rx_valid_q;
    assign tx_req_o   = tx_req_q;
    assign start_o    = start_q;
    assign stop_o     = stop_q;
    assign rw_o       = rw_q;
    assign busy_o     = busy_q;

endmodule

// File: doc/i2c_target_rsp.md
I2C_TARGET_RSP -- requirements
Module: i2c_target_rsp

Interface
REQ-001 Parameter I2C_ADDR_WIDTH, default 7: target address width.
REQ-002 Parameter I2C_DATA_WIDTH, default 8: byte width.
REQ-003 Parameter TARGET_ADDR, default 7'h22: address this block answers to.
REQ-004 clk_i  input  1  single system clock; all logic on its rising edge.
REQ-005 rst_i  input  1  reset; synchronous, active-high.
REQ-006 scl_i / sda_i  input  1 each  I2C bus levels, asynchronous to clk_i.
REQ-007 scl_o / sda_o  output  1 each  open-drain drive; 0 = pull low, 1 = release.
REQ-008 rx_data_o  output  I2C_DATA_WIDTH  last byte written by the controller.
REQ-009 rx_valid_o  output  1  one-cycle strobe; rx_data_o is valid.
REQ-010 tx_req_o  output  1  one-cycle strobe requesting the next read byte.
REQ-011 tx_data_i  input  I2C_DATA_WIDTH  read byte; tx_valid_i  input  1  tx_data_i accepted when high.
REQ-012 start_o / stop_o  output  1 each  one-cycle strobes on a detected START (including repeated START) and a detected STOP.
REQ-013 rw_o  output  1  R/W bit of the current addressed transfer; busy_o  output  1  high from an address match until STOP or a non-matching address.

Function
REQ-014 scl_i and sda_i SHALL each pass through a 2-flop synchronizer plus a previous-value register; edges are detected on the synchronized values (3-cycle input latency).
REQ-015 START = SDA fall while SCL high; STOP = SDA rise while SCL high; both SHALL be recognised in every state and take priority over bit sampling.
REQ-016 START SHALL force state ADDR from any state; STOP SHALL force IDLE and release scl_o/sda_o in the same cycle.
REQ-017 States: IDLE, ADDR, ADDR_ACK, WR_DATA, WR_ACK, RD_LOAD, RD_DATA, RD_ACK, IGNORE.
REQ-018 Bits SHALL be sampled MSB first on the SCL rising edge; sda_o changes only on the SCL falling edge.
REQ-019 ADDR: after 8 bits, if the upper 7 bits equal TARGET_ADDR, latch rw_o, set busy_o, go to ADDR_ACK; otherwise go to IGNORE and keep sda_o=1 (NACK).
REQ-020 ACK phase: drive sda_o=0 from the falling edge after bit 8 until the next falling edge.
REQ-021 Write (rw=0): each 8th data bit SHALL load rx_data_o and pulse rx_valid_o one cycle after the sampling edge; every byte is ACKed (WR_ACK); loop to WR_DATA.
REQ-022 Read (rw=1): on entering RD_LOAD, pulse tx_req_o and hold scl_o=0 (clock stretch) until tx_valid_i=1; then load the shift register, drive the MSB, release scl_o, go to RD_DATA.
REQ-023 If tx_valid_i is already high in the RD_LOAD entry cycle, no stretch occurs (scl_o stays 1).
REQ-024 RD_DATA: shift out on each falling edge; after bit 8 release sda_o and go to RD_ACK.
REQ-025 RD_ACK: controller ACK (SDA=0 at rise) -> RD_LOAD; NACK -> IGNORE until STOP or START.
REQ-026 tx_valid_i outside RD_LOAD SHALL be ignored; rx_valid_o and tx_req_o never assert in the same cycle.
REQ-027 IGNORE SHALL never drive scl_o or sda_o low.

Reset
REQ-028 While rst_i=1: state IDLE, scl_o=1, sda_o=1, rx_data_o=0, all strobes 0, rw_o=0, busy_o=0, synchronizers at 1.
REQ-029 Reset asserted mid-transfer SHALL release the bus on the next clock edge; after release the block responds only after a new START.

Structure
REQ-030 State enum, I2C_ADDR_WIDTH/I2C_DATA_WIDTH defaults and the START/STOP detect codes SHALL live in the shared i2c_enum_type package.
REQ-031 Sub-module i2c_sync_edge (2-flop synchronizer plus rise/fall detect) SHALL be instantiated once each for SCL and SDA.

Verification
REQ-032 Controller writes 0x44, then bytes 0..31, then STOP -> 32 rx_valid_o pulses carrying 0..31, 33 ACKs, stop_o once, busy_o low afterwards.
REQ-033 Controller reads 0x45 with tx_data 100..131 and NACKs the last byte -> 32 tx_req_o pulses, bytes 100..131 on the bus, state IGNORE then IDLE at STOP.
REQ-034 Address 0x46 (0x23 write) -> no ACK, busy_o stays 0, no strobes.
REQ-035 Write 0x44 + data 64, repeated START, read 0x45 with tx_data 63 -> start_o twice, rx byte 64, read byte 63.
REQ-036 tx_valid_i delayed 50 cycles after tx_req_o -> scl_o held 0 exactly until the cycle after tx_valid_i; data correct.
REQ-037 rst_i pulsed during bit 4 of a write byte -> scl_o=sda_o=1 next cycle, no rx_valid_o, and the next addressed transfer completes normally.
